// File: rtl/pd_pkg.sv
// Shared definitions for the serial pattern detector.
//   pd_state_e  : detector FSM states
//   pd_len_w()  : width needed to hold a pattern length 0..max_len
//   pd_sat_val(): all-ones saturation value for a counter of a given width
//   PD_CNT_W / PD_CNT_SAT : default counter width and its saturation value
package pd_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,   // no legal configuration loaded
        FILL  = 2'd1,   // fewer than len bits collected
        RUN   = 2'd2    // at least len bits collected
    } pd_state_e;

    function automatic int pd_len_w(input int max_len);
        return (max_len < 1) ? 1 : $clog2(max_len + 1);
    endfunction

    function automatic logic [63:0] pd_sat_val(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    localparam int          PD_CNT_W   = 8;
    localparam logic [63:0] PD_CNT_SAT = pd_sat_val(PD_CNT_W);

endpackage

// File: rtl/pd_sat_counter.sv
// Saturating up-counter.
//   clk   : rising-edge clock
//   reset : synchronous reset, active low
//   clr   : clear to zero (wins over inc)
//   inc   : count up by one, holding at all-ones
//   count : current value
//   sat   : high while count is all-ones
module pd_sat_counter
    import pd_pkg::*;
#(
    parameter int CNT_W = PD_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(pd_sat_val(CNT_W));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != SAT_VAL)) begin
            count <= count + 1'b1;
        end
    end

    assign sat = (count == SAT_VAL);

endmodule

// File: rtl/pattern_detector_param.sv
// Serial bit-pattern detector with runtime-programmable pattern/length,
// overlapping or non-overlapping matching and a saturating match counter.
//   clk, reset          : clock, synchronous active-low reset
//   cfg_load            : strobe latching cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern         : pattern, first-received bit at [cfg_len-1]
//   cfg_len             : pattern length, legal 1..MAX_LEN
//   cfg_overlap         : 1 = matches may share bits
//   cfg_err             : one-cycle pulse on a cfg_load with illegal length
//   data_valid, data_in : qualified serial input bit
//   detected            : one-cycle pulse per match (registered)
//   match_count         : saturating number of matches since reset/config
//   count_sat           : match_count is all-ones
//   configured          : a legal configuration is active
module pattern_detector_param
    import pd_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = pd_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               data_valid,
    input  logic               data_in,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat,
    output logic               configured
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    pd_state_e          state;
    logic [MAX_LEN-1:0] history;
    logic [LEN_W-1:0]   fill_cnt;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;

    logic               cfg_legal;
    logic               accept;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [LEN_W-1:0]   fill_nxt;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;

    always_comb begin
        cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_MAX);
        // cfg_load always wins over a same-cycle data bit
        accept    = data_valid && (state != UNCFG) && !cfg_load;
        // shift left, new bit at [0]; the cast drops the oldest bit
        hist_nxt  = MAX_LEN'({history, data_in});
        fill_nxt  = (fill_cnt == LEN_MAX) ? fill_cnt : fill_cnt + 1'b1;
        len_mask  = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len));
        end
        // bits above len are don't-care; fill gate stops stale history
        // (after reconfig or a non-overlap match) from matching
        match = accept
             && (((hist_nxt ^ pat) & len_mask) == '0)
             && (fill_nxt >= len);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= UNCFG;
            history    <= '0;
            fill_cnt   <= '0;
            pat        <= '0;
            len        <= '0;
            ovl        <= 1'b0;
            detected   <= 1'b0;
            cfg_err    <= 1'b0;
            configured <= 1'b0;
        end else begin
            detected <= match;
            cfg_err  <= cfg_load && !cfg_legal;
            if (cfg_load) begin
                // an illegal load leaves everything as it was
                if (cfg_legal) begin
                    pat        <= cfg_pattern;
                    len        <= cfg_len;
                    ovl        <= cfg_overlap;
                    history    <= '0;
                    fill_cnt   <= '0;
                    configured <= 1'b1;
                    state      <= FILL;
                end
            end else if (accept) begin
                history <= hist_nxt;
                if (match && !ovl) begin
                    fill_cnt <= '0;
                    state    <= FILL;
                end else begin
                    fill_cnt <= fill_nxt;
                    state    <= (fill_nxt >= len) ? RUN : FILL;
                end
            end
        end
    end

    pd_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cfg_load && cfg_legal),
        .inc   (match),
        .count (match_count),
        .sat   (count_sat)
    );

endmodule

// File: tb/tb_pattern_detector_param.sv
module tb_pattern_detector_param;

    localparam int ML = 8;
    localparam int LW = 4;

    typedef struct packed {
        logic          r;
        logic          l;
        logic [LW-1:0] len;
        logic          o;
        logic          v;
        logic          d;
        logic [ML-1:0] pat;
    } stim_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_load = 1'b0;
    logic [ML-1:0] cfg_pattern = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_overlap = 1'b0;
    logic          data_valid = 1'b0;
    logic          data_in = 1'b0;

    logic          cfg_err, detected, count_sat, configured;
    logic [7:0]    match_count;
    logic          cfg_err_s, detected_s, count_sat_s, configured_s;
    logic [1:0]    match_count_s;

    always #5 clk = ~clk;

    pattern_detector_param #(.MAX_LEN(ML), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
        .data_valid(data_valid), .data_in(data_in), .detected(detected),
        .match_count(match_count), .count_sat(count_sat), .configured(configured)
    );

    // second instance with a 2-bit counter, fed the same stimulus
    pattern_detector_param #(.MAX_LEN(ML), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err_s),
        .data_valid(data_valid), .data_in(data_in), .detected(detected_s),
        .match_count(match_count_s), .count_sat(count_sat_s), .configured(configured_s)
    );

    logic [17:0] obs;
    assign obs = {detected, cfg_err, configured, match_count, count_sat,
                  match_count_s, count_sat_s, detected_s, cfg_err_s, configured_s};

    // reference model: list of accepted bits since config / last non-overlap match
    bit            m_cfg;
    logic [ML-1:0] m_pat;
    int            m_len;
    bit            m_ovl;
    bit            hq[$];
    int            m_cnt;
    bit            m_det, m_err;
    logic [17:0]   exp_v;

    int vectors = 0;
    int miscompares = 0;

    function automatic stim_t mk_cfg(int len, logic [ML-1:0] pat, bit ovl, bit v = 0, bit d = 0);
        stim_t s;
        s = '{r:1'b1, l:1'b1, len:LW'(len), o:ovl, v:v, d:d, pat:pat};
        return s;
    endfunction

    function automatic stim_t mk_bit(bit v, bit d);
        stim_t s;
        s = '{r:1'b1, l:1'b0, len:'0, o:1'b0, v:v, d:d, pat:'0};
        return s;
    endfunction

    function automatic stim_t mk_rst(bit l, bit v, bit d);
        stim_t s;
        s = '{r:1'b0, l:l, len:LW'(4), o:1'b1, v:v, d:d, pat:8'h0B};
        return s;
    endfunction

    task automatic step(input stim_t s);
        bit hit;
        reset = s.r; cfg_load = s.l; cfg_len = s.len; cfg_pattern = s.pat;
        cfg_overlap = s.o; data_valid = s.v; data_in = s.d;
        @(posedge clk);
        #1;
        m_det = 0;
        m_err = 0;
        if (!s.r) begin
            m_cfg = 0; m_pat = '0; m_len = 0; m_ovl = 0; hq.delete(); m_cnt = 0;
        end else if (s.l) begin
            if (s.len >= 1 && s.len <= ML) begin
                m_cfg = 1; m_pat = s.pat; m_len = int'(s.len); m_ovl = s.o;
                hq.delete(); m_cnt = 0;
            end else begin
                m_err = 1;
            end
        end else if (s.v && m_cfg) begin
            hq.push_back(s.d);
            if (hq.size() > ML) void'(hq.pop_front());
            hit = (hq.size() >= m_len);
            for (int i = 0; i < m_len && hit; i++)
                if (hq[hq.size() - 1 - i] != m_pat[i]) hit = 0;
            if (hit) begin
                m_det = 1;
                m_cnt++;
                if (!m_ovl) hq.delete();
            end
        end
        exp_v = {m_det, m_err, m_cfg, 8'((m_cnt > 255) ? 255 : m_cnt), (m_cnt >= 255),
                 2'((m_cnt > 3) ? 3 : m_cnt), (m_cnt >= 3), m_det, m_err, m_cfg};
    endtask

    task automatic test_reset();
        step(mk_rst(1'b0, 1'b0, 1'b0));
        vectors++;
        if (obs !== 18'd0) begin
            miscompares++;
            $display("FAIL reset: got %h want %h", obs, 18'd0);
        end
    endtask

    task automatic test_unconfigured();
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            step(mk_bit(1, 1));
            n += int'(detected);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL unconfigured i=%0d: got %h want %h", i, obs, exp_v);
            end
        end
        vectors++;
        if (n != 0 || configured !== 1'b0) begin
            miscompares++;
            $display("FAIL unconfigured_pulses: got %0d/%b want 0/0", n, configured);
        end
    endtask

    task automatic test_match_stream(input bit ovl, input int want);
        logic [6:0] bits = 7'b1011011;
        stim_t q[$];
        int n = 0;
        q.push_back(mk_cfg(4, 8'h0B, ovl));
        for (int i = 6; i >= 0; i--) q.push_back(mk_bit(1, bits[i]));
        foreach (q[i]) begin
            step(q[i]);
            n += int'(detected);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL stream ovl=%0d i=%0d: got %h want %h", ovl, i, obs, exp_v);
            end
        end
        vectors++;
        if (n != want || match_count !== 8'(want)) begin
            miscompares++;
            $display("FAIL stream_total ovl=%0d: got %0d pulses cnt %0d want %0d", ovl, n, match_count, want);
        end
    endtask

    task automatic test_overlap();
        test_match_stream(1'b1, 2);
    endtask

    task automatic test_non_overlap();
        test_match_stream(1'b0, 1);
    endtask

    task automatic test_valid_gaps();
        logic [3:0] bits = 4'b1011;
        stim_t q[$];
        int n = 0;
        q.push_back(mk_cfg(4, 8'h0B, 1'b1));
        for (int i = 3; i >= 0; i--) begin
            q.push_back(mk_bit(1, bits[i]));
            q.push_back(mk_bit(0, 1'($urandom)));
            q.push_back(mk_bit(0, 1'($urandom)));
        end
        foreach (q[i]) begin
            step(q[i]);
            n += int'(detected);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL gaps i=%0d: got %h want %h", i, obs, exp_v);
            end
        end
        vectors++;
        if (n != 1) begin
            miscompares++;
            $display("FAIL gaps_pulses: got %0d want 1", n);
        end
    endtask

    task automatic test_saturation();
        stim_t q[$];
        int n = 0;
        q.push_back(mk_cfg(1, 8'h01, 1'b1));
        for (int i = 0; i < 5; i++) q.push_back(mk_bit(1, 1));
        foreach (q[i]) begin
            step(q[i]);
            n += int'(detected_s);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL saturation i=%0d: got %h want %h", i, obs, exp_v);
            end
        end
        vectors++;
        if (n != 5 || match_count_s !== 2'd3 || count_sat_s !== 1'b1 || match_count !== 8'd5) begin
            miscompares++;
            $display("FAIL saturation_total: got %0d pulses cnt2 %0d cnt8 %0d want 5/3/5", n, match_count_s, match_count);
        end
    endtask

    task automatic test_cfg_errors();
        stim_t q[$];
        int errs = 0;
        q.push_back(mk_cfg(4, 8'h0B, 1'b1));
        q.push_back(mk_bit(1, 1)); q.push_back(mk_bit(1, 0)); q.push_back(mk_bit(1, 1));
        q.push_back(mk_cfg(0, 8'hFF, 1'b0));          // illegal, old config kept
        q.push_back(mk_bit(1, 1));                    // completes 1011
        q.push_back(mk_cfg(9, 8'h00, 1'b0, 1, 0));    // illegal, bit discarded
        q.push_back(mk_cfg(15, 8'h00, 1'b0));
        q.push_back(mk_cfg(4, 8'h0B, 1'b1, 1, 1));    // legal, bit discarded
        q.push_back(mk_bit(1, 0)); q.push_back(mk_bit(1, 1)); q.push_back(mk_bit(1, 1));
        q.push_back(mk_cfg(8, 8'hA5, 1'b0));          // boundary length
        for (int i = 7; i >= 0; i--) q.push_back(mk_bit(1, (8'hA5 >> i) & 1));
        foreach (q[i]) begin
            step(q[i]);
            errs += int'(cfg_err);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL cfg_errors i=%0d: got %h want %h", i, obs, exp_v);
            end
        end
        vectors++;
        if (errs != 3) begin
            miscompares++;
            $display("FAIL cfg_err_pulses: got %0d want 3", errs);
        end
    endtask

    task automatic test_reset_midstream();
        stim_t q[$];
        int n = 0;
        q.push_back(mk_cfg(4, 8'h0B, 1'b1));
        q.push_back(mk_bit(1, 1)); q.push_back(mk_bit(1, 0)); q.push_back(mk_bit(1, 1));
        q.push_back(mk_rst(1'b1, 1'b1, 1'b1));        // reset beats cfg_load
        q.push_back(mk_bit(1, 1)); q.push_back(mk_bit(1, 0));
        q.push_back(mk_bit(1, 1)); q.push_back(mk_bit(1, 1));
        foreach (q[i]) begin
            step(q[i]);
            if (i >= 4) n += int'(detected);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_mid i=%0d: got %h want %h", i, obs, exp_v);
            end
        end
        vectors++;
        if (n != 0 || configured !== 1'b0 || match_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid_final: got %0d pulses cfg %b cnt %0d want 0/0/0", n, configured, match_count);
        end
    endtask

    task automatic test_random();
        stim_t s;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                s = mk_rst(1'($urandom), 1'($urandom), 1'($urandom));
            end else if ($urandom_range(0, 49) == 0) begin
                s = mk_cfg(($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4),
                           8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                s = mk_bit($urandom_range(0, 9) < 7, 1'($urandom));
            end
            step(s);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL random i=%0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unconfigured();
        test_overlap();
        test_non_overlap();
        test_valid_gaps();
        test_saturation();
        test_cfg_errors();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
